// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: hazard vector bit indices,
// bubble encoding, reset PC and the IF/ID bundle.
package if_stage_pkg;

  localparam int STALL_PC   = 0;
  localparam int STALL_IFID = 1;
  localparam int FLUSH_IFID = 0;
  localparam int FLUSH_IDEX = 1;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] pc_plus4(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Next-PC priority mux: branch, jump, hold, sequential.
// Purely combinational so the single-cycle core can reuse it.
module pc_next_sel
  import if_stage_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_branch,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_hold,
  output logic [31:0] o_next_pc
);

  // The branch in EX is older than the jump in ID, so it wins.
  always_comb begin
    o_next_pc = pc_plus4(i_pc);
    if (i_branch)
      o_next_pc = i_branch_target;
    else if (i_jump)
      o_next_pc = i_jump_target;
    else if (i_hold)
      o_next_pc = i_pc;
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, next-PC selection, imem request
// and the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  stall,
  input  logic [4:0]  flush,
  input  logic        ID_jump,
  input  logic [31:0] jump_target,
  input  logic        EX_branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid,
  output logic [4:0]  IF_ID_rs,
  output logic [4:0]  IF_ID_rt
);

  logic [31:0] r_pc;
  if_id_t      r_ifid;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc4;
  logic        w_redirect;
  logic        w_squash;
  logic        w_hold_pc;
  logic        w_unused;

  assign w_pc4      = pc_plus4(r_pc);
  assign w_redirect = EX_branch_taken | ID_jump;
  assign w_squash   = flush[FLUSH_IFID] | w_redirect;
  assign w_hold_pc  = stall[STALL_PC] | ~imem_ready;
  assign w_unused   = ^{stall[4:2], flush[4:1]};

  pc_next_sel u_pc_next_sel (
    .i_pc           (r_pc),
    .i_branch       (EX_branch_taken),
    .i_branch_target(branch_target),
    .i_jump         (ID_jump),
    .i_jump_target  (jump_target),
    .i_hold         (w_hold_pc),
    .o_next_pc      (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_ifid <= '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};
    end else begin
      r_pc <= w_next_pc;
      if (w_squash) begin
        r_ifid <= '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};
      end else if (!stall[STALL_IFID]) begin
        if (imem_ready)
          r_ifid <= '{instr: imem_rdata, pc4: w_pc4,
                      valid: 1'b1};
        else
          r_ifid <= '{instr: NOP_INSTR, pc4: 32'd0,
                      valid: 1'b0};
      end
    end
  end

  assign imem_addr   = r_pc;
  assign IF_ID_instr = r_ifid.instr;
  assign IF_ID_pc4   = r_ifid.pc4;
  assign IF_ID_valid = r_ifid.valid;
  assign IF_ID_rs    = r_ifid.instr[25:21];
  assign IF_ID_rt    = r_ifid.instr[20:16];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stalls,
// redirects, imem wait states, reset and PC wrap.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic        ID_jump;
  logic [31:0] jump_target;
  logic        EX_branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ID_jump        (ID_jump),
    .jump_target    (jump_target),
    .EX_branch_taken(EX_branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_pc4      (IF_ID_pc4),
    .IF_ID_valid    (IF_ID_valid),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt)
  );

  // Instruction memory image: address-dependent word.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h8C00_0000 ^ {a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0;
    ID_jump = 0; jump_target = 0;
    EX_branch_taken = 0; branch_target = 0;
    imem_ready = 1;
  endtask

  // Checks a valid IF/ID entry fetched from address a.
  task automatic chk_ifid(input string tag, input logic [31:0] a);
    logic [31:0] w;
    w = mem(a);
    chk({tag, ".instr"}, IF_ID_instr, w);
    chk({tag, ".pc4"}, IF_ID_pc4, a + 32'd4);
    chk({tag, ".valid"}, {31'd0, IF_ID_valid}, 32'd1);
    chk({tag, ".rs"}, {27'd0, IF_ID_rs}, {27'd0, w[25:21]});
    chk({tag, ".rt"}, {27'd0, IF_ID_rt}, {27'd0, w[20:16]});
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".instr"}, IF_ID_instr, 32'h0);
    chk({tag, ".valid"}, {31'd0, IF_ID_valid}, 32'd0);
    chk({tag, ".rs"}, {27'd0, IF_ID_rs}, 32'd0);
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    step();
    chk("rst.pc", imem_addr, 32'h0);
    chk("rst.pc4", IF_ID_pc4, 32'h0);
    chk_bubble("rst");

    // 1: sequential fetch
    reset = 0;
    step();
    chk("seq.pc1", imem_addr, 32'h4);
    chk_ifid("seq1", 32'h0);
    step();
    chk("seq.pc2", imem_addr, 32'h8);
    chk_ifid("seq2", 32'h4);

    // 2: full stall at PC=8, then release
    stall = 5'b00011;
    step();
    step();
    chk("stl.pc", imem_addr, 32'h8);
    chk_ifid("stl", 32'h4);
    stall = 0;
    step();
    chk("rel.pc", imem_addr, 32'hC);
    chk_ifid("rel", 32'h8);

    // 3: jump from PC=C
    ID_jump = 1; jump_target = 32'h40;
    step();
    chk("jmp.pc", imem_addr, 32'h40);
    chk("jmp.pc4", IF_ID_pc4, 32'h0);
    chk_bubble("jmp");
    idle();
    step();
    chk("jmp2.pc", imem_addr, 32'h44);
    chk_ifid("jmp2", 32'h40);

    // 4: branch beats jump and stall
    EX_branch_taken = 1; branch_target = 32'h100;
    ID_jump = 1; jump_target = 32'h200;
    stall = 5'b00011;
    step();
    chk("br.pc", imem_addr, 32'h100);
    chk_bubble("br");
    idle();

    // flush[0] alone squashes IF/ID but PC still advances
    flush = 5'b00001;
    step();
    chk("fl.pc", imem_addr, 32'h104);
    chk_bubble("fl");
    idle();

    // 5: imem wait states at PC=10
    ID_jump = 1; jump_target = 32'h10;
    step();
    chk("j10.pc", imem_addr, 32'h10);
    idle();
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait.pc", imem_addr, 32'h10);
      chk_bubble("wait");
    end
    imem_ready = 1;
    step();
    chk("rdy.pc", imem_addr, 32'h14);
    chk_ifid("rdy", 32'h10);

    // stall[1] holds IF/ID even while imem is not ready
    stall = 5'b00011; imem_ready = 0;
    step();
    chk("hld.pc", imem_addr, 32'h14);
    chk_ifid("hld", 32'h10);
    idle();

    // 6: reset beats a branch
    reset = 1;
    EX_branch_taken = 1; branch_target = 32'h300;
    step();
    chk("rbr.pc", imem_addr, 32'h0);
    chk_bubble("rbr");
    idle();
    step();
    chk("rbr2.pc", imem_addr, 32'h4);
    chk_ifid("rbr2", 32'h0);

    // PC wraps modulo 2^32
    EX_branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    step();
    chk("wr.pc", imem_addr, 32'hFFFF_FFFC);
    idle();
    step();
    chk("wrap.pc", imem_addr, 32'h0);
    chk("wrap.instr", IF_ID_instr, mem(32'hFFFF_FFFC));
    chk("wrap.pc4", IF_ID_pc4, 32'h0);
    chk("wrap.valid", {31'd0, IF_ID_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
